// File: rtl/mix_engine.sv
// -----------------------------------------------------------------------------
// mix_engine -- NCH-channel gain/mute audio mixer with saturation.
//
// A strobe captures all channel samples, gains and mutes into shadow
// registers. The channels are then multiplied and accumulated one per cycle.
// The sum is scaled so that a gain of 2^(GW-1) is unity, clamped to W bits,
// and presented in offset-binary form.
//
// Product pipeline: each channel product is registered before it is added.
// That extra stage makes the strobe-to-result latency NCH+2 edges. It also
// keeps the multiplier and the adder in separate cycles.
//
// Optional build macro:
//   MIX_PEAK_EN  builds the magnitude peak meter on 'peak'.
//                When the macro is undefined, 'peak' is tied to zero.
//
// Ports:
//   hz2m       clock, rising edge
//   reset      synchronous active-high reset
//   smpl_stb   start a mix (single-cycle pulse)
//   ch_data    NCH signed W-bit samples, channel i at [i*W +: W]
//   ch_gain    NCH unsigned GW-bit gains, channel i at [i*GW +: GW]
//   ch_mute    per-channel mute
//   busy       mix in progress
//   mix_valid  one-cycle pulse when mix_out/clip update
//   mix_out    offset-binary mixed sample, holds between updates
//   clip       current mix_out was saturated
//   overrun    sticky: strobe seen while busy
//   peak       magnitude peak meter (zero unless MIX_PEAK_EN)
// -----------------------------------------------------------------------------
module mix_engine #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int GW  = 4
) (
  input  logic              hz2m,
  input  logic              reset,
  input  logic              smpl_stb,
  input  logic [NCH*W-1:0]  ch_data,
  input  logic [NCH*GW-1:0] ch_gain,
  input  logic [NCH-1:0]    ch_mute,
  output logic              busy,
  output logic              mix_valid,
  output logic [W-1:0]      mix_out,
  output logic              clip,
  output logic              overrun,
  output logic [W-2:0]      peak
);

  localparam int IW = $clog2(NCH + 1);          // index counts 0..NCH
  localparam int SW = $clog2(NCH);              // channel select width
  localparam int PW = W + GW + 1;               // signed x unsigned product
  localparam int AW = W + GW + $clog2(NCH) + 1; // accumulator
  localparam logic [IW-1:0]        IDX_LAST = IW'(NCH);
  localparam logic signed [AW-1:0] SAT_MAX  = AW'((2 ** (W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [W-1:0]         MIDSCALE = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

  state_t                  state_q, state_d;
  logic [NCH*W-1:0]        data_sh_q, data_sh_d;
  logic [NCH*GW-1:0]       gain_sh_q, gain_sh_d;
  logic [NCH-1:0]          mute_sh_q, mute_sh_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [W-1:0]            mix_out_q, mix_out_d;
  logic                    mix_valid_q, mix_valid_d;
  logic                    clip_q, clip_d;
  logic                    overrun_q, overrun_d;

  // Per-channel views of the shadow registers.
  logic signed [W-1:0] data_arr [NCH];
  logic [GW-1:0]       gain_arr [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign data_arr[gi] = data_sh_q[gi*W +: W];
      assign gain_arr[gi] = gain_sh_q[gi*GW +: GW];
    end
  endgenerate

  // The index reaches NCH in the final drain cycle; point the mux at a
  // harmless channel then (that product is never accumulated).
  logic [SW-1:0]        sel;
  logic signed [PW-1:0] ch_prod;
  assign sel     = (idx_q < IDX_LAST) ? idx_q[SW-1:0] : '0;
  assign ch_prod = mute_sh_q[sel] ? '0
                 : PW'(data_arr[sel]) * PW'($signed({1'b0, gain_arr[sel]}));

  // Scale back to unity gain (floor shift) and clamp to W bits.
  logic signed [AW-1:0] shifted;
  logic signed [W-1:0]  sat_val;
  logic                 sat_hit;
  always_comb begin
    shifted = acc_q >>> (GW - 1);
    sat_val = shifted[W-1:0];
    sat_hit = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(W - 1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(W - 1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_sh_d   = data_sh_q;
    gain_sh_d   = gain_sh_q;
    mute_sh_d   = mute_sh_q;
    idx_d       = idx_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    clip_d      = clip_q;
    mix_valid_d = 1'b0;
    overrun_d   = overrun_q | (smpl_stb & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (smpl_stb) begin
          data_sh_d = ch_data;
          gain_sh_d = ch_gain;
          mute_sh_d = ch_mute;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        // Product of channel idx is registered now.
        // The product of channel idx-1 is added now.
        prod_d = ch_prod;
        if (idx_q != '0) begin
          acc_d = acc_q + AW'(prod_q);
        end
        if (idx_q == IDX_LAST) begin
          state_d = SAT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SAT: begin
        mix_out_d   = {~sat_val[W-1], sat_val[W-2:0]};
        clip_d      = sat_hit;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hz2m) begin
    if (reset) begin
      state_q     <= IDLE;
      data_sh_q   <= '0;
      gain_sh_q   <= '0;
      mute_sh_q   <= '0;
      idx_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      mix_out_q   <= MIDSCALE;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_sh_q   <= data_sh_d;
      gain_sh_q   <= gain_sh_d;
      mute_sh_q   <= mute_sh_d;
      idx_q       <= idx_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef MIX_PEAK_EN
  logic [W-2:0] peak_q, peak_d, mag;
  logic [W-1:0] neg_val;

  // |result|, with the most negative code saturating to full scale.
  // Peak is updated on the same edge that produces mix_valid.
  always_comb begin
    neg_val = -sat_val;
    if (sat_val == {1'b1, {(W - 1){1'b0}}}) begin
      mag = '1;
    end else if (sat_val[W-1]) begin
      mag = neg_val[W-2:0];
    end else begin
      mag = sat_val[W-2:0];
    end
    peak_d = peak_q;
    if (state_q == SAT) begin
      if (mag > peak_q) begin
        peak_d = mag;
      end else if (peak_q != '0) begin
        peak_d = peak_q - 1'b1;
      end
    end
  end

  always_ff @(posedge hz2m) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign busy      = (state_q != IDLE);
  assign mix_valid = mix_valid_q;
  assign mix_out   = mix_out_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mix_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_engine -- scoreboard testbench for mix_engine (default parameters).
// The driver computes each mix with plain integer arithmetic and queues the
// expected result. A monitor compares the queued result on every mix_valid
// and tracks the busy/overrun/hold behaviour cycle by cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mix_engine;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int GW  = 4;
  localparam int LAT = NCH + 2;

  logic              hz2m = 1'b0;
  logic              reset = 1'b1;
  logic              smpl_stb = 1'b0;
  logic [NCH*W-1:0]  ch_data = '0;
  logic [NCH*GW-1:0] ch_gain = '0;
  logic [NCH-1:0]    ch_mute = '0;
  logic              busy, mix_valid, clip, overrun;
  logic [W-1:0]      mix_out;
  logic [W-2:0]      peak;

  mix_engine #(.NCH(NCH), .W(W), .GW(GW)) dut (
    .hz2m(hz2m), .reset(reset), .smpl_stb(smpl_stb),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_mute(ch_mute),
    .busy(busy), .mix_valid(mix_valid), .mix_out(mix_out),
    .clip(clip), .overrun(overrun), .peak(peak)
  );

  always #5 hz2m = ~hz2m;

  typedef struct {
    int due;
    int out;
    int clip;
    int mag;
    int pk;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1000;
  int last_due = -1000;
  int overrun_m = 0;
  int peak_m = 0;
  int out_m = 128;
  int clip_m = 0;
  int pk_now = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference mix: sum of data*gain over unmuted channels, floor-divide by
  // unity gain, clamp to the signed W-bit range, offset by midscale.
  function automatic exp_t model(input logic [NCH*W-1:0] d, input logic [NCH*GW-1:0] g,
                                 input logic [NCH-1:0] m);
    exp_t r;
    int sum;
    int res;
    int maxv;
    int minv;
    logic signed [W-1:0] dv;
    logic [GW-1:0] gv;
    sum  = 0;
    maxv = (1 << (W - 1)) - 1;
    minv = -(1 << (W - 1));
    for (int i = 0; i < NCH; i++) begin
      dv = d[i*W +: W];
      gv = g[i*GW +: GW];
      if (!m[i]) sum += int'(dv) * int'(gv);
    end
    res    = sum >>> (GW - 1);
    r.clip = (res > maxv || res < minv) ? 1 : 0;
    if (res > maxv) res = maxv;
    if (res < minv) res = minv;
    r.out = res + (1 << (W - 1));
    r.mag = (res < 0) ? -res : res;
    if (r.mag > maxv) r.mag = maxv;
    r.due = 0;
    r.pk  = 0;
    return r;
  endfunction

  // Drive one strobe (called just after a falling edge). Scrambles the inputs
  // one cycle later so any leak past the shadow registers shows up.
  task automatic strobe(input logic [NCH*W-1:0] d, input logic [NCH*GW-1:0] g,
                        input logic [NCH-1:0] m);
    int e;
    exp_t x;
    ch_data  = d;
    ch_gain  = g;
    ch_mute  = m;
    smpl_stb = 1'b1;
    e = cyc + 1;
    if (e > last_due) begin
      x = model(d, g, m);
      x.due = e + LAT;
`ifdef MIX_PEAK_EN
      if (x.mag > peak_m) peak_m = x.mag;
      else if (peak_m > 0) peak_m = peak_m - 1;
      x.pk = peak_m;
`else
      x.pk = 0;
`endif
      exp_q.push_back(x);
      last_acc = e;
      last_due = x.due;
      $display("strobe edge %0d: data=%h gain=%h mute=%b -> expect out=%02h clip=%0d at edge %0d",
               e, d, g, m, x.out, x.clip, x.due);
    end else begin
      overrun_m = 1;
      $display("strobe edge %0d: engine busy, strobe ignored", e);
    end
    @(negedge hz2m);
    smpl_stb = 1'b0;
    ch_data  = $urandom;
    ch_gain  = $urandom;
    ch_mute  = 4'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    last_acc  = -1000;
    last_due  = -1000;
    overrun_m = 0;
    peak_m    = 0;
    pk_now    = 0;
    out_m     = 128;
    clip_m    = 0;
    repeat (n) @(negedge hz2m);
    reset = 1'b0;
  endtask

  // Returns at the falling edge inside the mix_valid cycle of the last mix.
  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < last_due && n < 100) begin
      @(negedge hz2m);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 1, 0);
  endtask

  // Monitor: samples 1 ns after every rising edge.
  always begin
    exp_t x;
    @(posedge hz2m);
    cyc++;
    #1;
    if (!reset) begin
      chk("busy", busy, (cyc >= last_acc && cyc < last_due) ? 1 : 0);
      chk("busy_valid_exclusive", busy & mix_valid, 0);
      chk("overrun", overrun, overrun_m);
      if (mix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mix_valid: got mix_out=%02h, expected no pulse (edge %0d)",
                   mix_out, cyc);
        end else begin
          x = exp_q.pop_front();
          chk("latency", cyc, x.due);
          chk("mix_out", mix_out, x.out);
          chk("clip", clip, x.clip);
          chk("peak", peak, x.pk);
          out_m  = x.out;
          clip_m = x.clip;
          pk_now = x.pk;
          $display("mix edge %0d: out=%02h clip=%0d peak=%0d", cyc, mix_out, clip, peak);
        end
      end else begin
        chk("mix_out_hold", mix_out, out_m);
        chk("clip_hold", clip, clip_m);
        chk("peak_hold", peak, pk_now);
        if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
          x = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_mix_valid: got no pulse, expected out=%02h at edge %0d",
                   x.out, x.due);
        end
      end
    end
  end

  initial begin
    int gap;
    int k;
    logic [NCH-1:0] m;

    // Power-on reset, two cycles.
    repeat (2) @(negedge hz2m);
    reset = 1'b0;
    chk("reset_mix_out", mix_out, 8'h80);
    chk("reset_busy", busy, 0);
    chk("reset_mix_valid", mix_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_peak", peak, 0);

    // Basic mix, clipping both ways, single channel, and muting.
    strobe({8'd40, 8'd30, 8'd20, 8'd10}, {4'd8, 4'd8, 4'd8, 4'd8}, 4'b0000);
    wait_idle();
    @(negedge hz2m);
    strobe({4{8'd100}}, {4{4'd8}}, 4'b0000);
    wait_idle();
    strobe({4{8'h9C}}, {4{4'd8}}, 4'b0000);
    wait_idle();
    @(negedge hz2m);
    strobe({8'd0, 8'd0, 8'd0, 8'hFD}, {4'd8, 4'd8, 4'd8, 4'd4}, 4'b1110);
    wait_idle();
    strobe({8'd0, 8'd0, 8'd0, 8'h7F}, {4{4'd8}}, 4'b0001);
    wait_idle();

    // Re-strobe two edges into a mix; then strobe in the mix_valid cycle.
    strobe({8'd1, 8'd2, 8'd3, 8'd4}, {4'd8, 4'd8, 4'd8, 4'd15}, 4'b0000);
    @(negedge hz2m);
    strobe({8'd90, 8'd90, 8'd90, 8'd90}, {4{4'd15}}, 4'b0000);
    wait_idle();
    strobe({8'hF0, 8'd5, 8'd7, 8'h81}, {4'd3, 4'd9, 4'd1, 4'd8}, 4'b0100);
    wait_idle();
    chk("overrun_sticky", overrun, 1);

    // Reset sampled on the third ACCUM edge aborts the mix.
    strobe({8'd50, 8'd50, 8'd50, 8'd50}, {4{4'd8}}, 4'b0000);
    @(negedge hz2m);
    @(negedge hz2m);
    do_reset(1);
    chk("abort_busy", busy, 0);
    chk("abort_mix_valid", mix_valid, 0);
    chk("abort_mix_out", mix_out, 8'h80);
    repeat (LAT + 2) @(negedge hz2m);
    strobe({8'd12, 8'hE0, 8'd33, 8'd7}, {4'd8, 4'd4, 4'd12, 4'd2}, 4'b0000);
    wait_idle();

    // Randomized traffic: random gaps (0 = back-to-back), occasional mutes
    // and occasional ignored strobes during a mix.
    for (int t = 0; t < 60; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge hz2m);
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      strobe($urandom, $urandom, m);
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, NCH + 1);
        repeat (k - 1) @(negedge hz2m);
        strobe($urandom, $urandom, 4'($urandom));
      end
      wait_idle();
    end

    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(negedge hz2m);
      k++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(negedge hz2m);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
